// File: rtl/posit_defines.sv
// Shared types and helpers for the quire-to-posit rounding pipeline.
// Holds the per-stage flag bundle and posit/quire geometry functions.
package posit_defines;

  typedef struct packed {
    logic sign;
    logic zero;
    logic nar;
  } quire_flags_t;

  function automatic int quire_frac(input int n, input int es);
    return (1 << (es + 1)) * (n - 2);
  endfunction

  // Fraction bits kept after normalisation: largest fraction plus guard.
  function automatic int keep_bits(input int n, input int es);
    return (n - 2 - es > 0) ? (n - 2 - es) : 1;
  endfunction

  function automatic logic [63:0] maxpos_field(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] minpos_field();
    return 64'd1;
  endfunction

endpackage

// File: rtl/LOD_N.sv
// Leading-one detector: returns the count of zeros above the first one.
// An all-zero input reports zero; callers flag that case separately.
module LOD_N #(
  parameter int N = 128
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] lzc
);

  logic found;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && vec[i]) begin
        found = 1'b1;
        lzc   = $clog2(N)'(N - 1 - i);
      end
    end
  end

endmodule

// File: rtl/posit_quire_round_pipe.sv
// Three-stage pipeline rounding a fixed-point quire to an n-bit posit.
// Stages: sign/magnitude, normalise, regime build and RNE rounding.
module posit_quire_round_pipe
  import posit_defines::*;
#(
  parameter int QUIRE_WIDTH = 128,
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 1,
  parameter int QUIRE_FRAC  = quire_frac(POSIT_WIDTH, POSIT_ES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [QUIRE_WIDTH-1:0] s_quire,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [POSIT_WIDTH-1:0] m_posit,
  output logic                   m_inexact,
  output logic                   m_sat,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int QW = QUIRE_WIDTH;
  localparam int N  = POSIT_WIDTH;
  localparam int LW = $clog2(QW);
  localparam int SW = LW + 2;
  localparam int FB = keep_bits(N, POSIT_ES);
  localparam int B  = 2 + POSIT_ES + FB;
  localparam int X  = B + N;

  localparam logic [N-2:0] MAXF = (N-1)'(maxpos_field(N));
  localparam logic [N-2:0] MINF = (N-1)'(minpos_field());

  typedef struct packed {
    quire_flags_t   f;
    logic [QW-1:0]  mag;
  } s1_t;

  typedef struct packed {
    quire_flags_t   f;
    logic [SW-1:0]  scale;
    logic           hidden;
    logic [FB-1:0]  frac;
    logic           sticky;
  } s2_t;

  logic en;
  logic v1, v2;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign en      = ~m_valid | m_ready;
  assign s_ready = en;

  always_comb begin
    s1_d        = '0;
    s1_d.f.sign = s_quire[QW-1];
    s1_d.f.zero = ~|s_quire;
    s1_d.f.nar  = s_quire[QW-1] & ~|s_quire[QW-2:0];
    s1_d.mag    = s_quire[QW-1] ? -s_quire : s_quire;
  end

  logic [LW-1:0] lzc;
  logic [QW-1:0] norm;

  LOD_N #(.N(QW)) u_lod (
    .vec (s1_q.mag),
    .lzc (lzc)
  );

  always_comb begin
    norm        = s1_q.mag << lzc;
    s2_d        = '0;
    s2_d.f      = s1_q.f;
    s2_d.scale  = SW'(QW - 1 - QUIRE_FRAC) - SW'(lzc);
    s2_d.hidden = norm[QW-1];
    s2_d.frac   = norm[QW-2 -: FB];
    s2_d.sticky = |norm[QW-2-FB:0];
  end

  logic signed [SW-1:0] k;
  logic [SW-1:0]        sh, shc;
  logic [B-1:0]         exp_b, base;
  logic signed [X-1:0]  vec_s;
  logic [X-1:0]         shifted;
  logic [N-2:0]         fld, mag_f;
  logic                 grd, stk, clamp, zero_c;
  logic [N-1:0]         rnd, pos;
  logic [N-1:0]         posit_d;
  logic                 inexact_d, sat_d;

  // Arithmetic shift of "10.." or "01.." grows the regime run with the
  // correct fill bit, so both regime signs share one shifter.
  always_comb begin
    k       = $signed(s2_q.scale) >>> POSIT_ES;
    sh      = k[SW-1] ? ~k : k;
    shc     = (sh > SW'(N)) ? SW'(N) : sh;
    exp_b   = B'(s2_q.scale) & B'((1 << POSIT_ES) - 1);
    base    = (B'({~k[SW-1], k[SW-1]}) << (POSIT_ES + FB))
            | (exp_b << FB)
            | B'(s2_q.frac);
    vec_s   = {base, {N{1'b0}}};
    shifted = vec_s >>> shc;
    fld     = shifted[X-1 -: N-1];
    grd     = shifted[X-N];
    stk     = (|shifted[X-N-1:0]) | s2_q.sticky;
    rnd     = {1'b0, fld} + {{(N-1){1'b0}}, grd & (stk | fld[0])};
    clamp   = 1'b0;
    mag_f   = rnd[N-2:0];
    if (rnd[N-1]) begin
      mag_f = MAXF;
      clamp = 1'b1;
    end else if (rnd[N-2:0] == '0) begin
      mag_f = MINF;
      clamp = 1'b1;
    end
    pos    = {1'b0, mag_f};
    zero_c = s2_q.f.zero | ~s2_q.hidden;
  end

  always_comb begin
    posit_d   = '0;
    inexact_d = 1'b0;
    sat_d     = 1'b0;
    unique case (1'b1)
      s2_q.f.nar: begin
        posit_d = {1'b1, {(N-1){1'b0}}};
      end
      zero_c: begin
        posit_d = '0;
      end
      default: begin
        posit_d   = s2_q.f.sign ? -pos : pos;
        inexact_d = grd | stk | clamp;
        sat_d     = clamp;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      m_valid   <= 1'b0;
      m_posit   <= '0;
      m_inexact <= 1'b0;
      m_sat     <= 1'b0;
    end else if (en) begin
      v1      <= s_valid;
      v2      <= v1;
      m_valid <= v2;
      if (v2) begin
        m_posit   <= posit_d;
        m_inexact <= inexact_d;
        m_sat     <= sat_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && s_valid) s1_q <= s1_d;
    if (en && v1)      s2_q <= s2_d;
  end

endmodule

// File: tb/tb_posit_quire_round_pipe.sv
// Bench for posit_quire_round_pipe: directed cases, random traffic,
// backpressure stall and mid-flight reset against an arithmetic model.
module tb_posit_quire_round_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_quire;
  logic         s_valid;
  logic         s_ready;
  logic [15:0]  m_posit;
  logic         m_inexact;
  logic         m_sat;
  logic         m_valid;
  logic         m_ready;

  always #5 clk = ~clk;

  posit_quire_round_pipe #(
    .QUIRE_WIDTH (128),
    .POSIT_WIDTH (16),
    .POSIT_ES    (1),
    .QUIRE_FRAC  (56)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_quire   (s_quire),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_posit   (m_posit),
    .m_inexact (m_inexact),
    .m_sat     (m_sat),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  int checks = 0;
  int errors = 0;
  int sent   = 0;
  int got    = 0;
  logic [17:0] exp_q[$];
  logic        use_spec = 1'b0;
  logic [17:0] spec_exp = '0;

  localparam logic [127:0] NAR = {1'b1, 127'd0};

  // Exact posit value of the quire, rounded RNE, as {sat, inexact, posit}.
  function automatic logic [17:0] ref_round(input logic [127:0] q);
    logic [127:0] mag;
    logic [511:0] pre, xs, fld, rem, half;
    int p, sc, k, e, r, d;
    logic sat, inx;
    logic [15:0] pos;
    if (q == '0) return '0;
    if (q == NAR) return {2'b00, 16'h8000};
    mag = q[127] ? -q : q;
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    sc = p - 56;
    k = (sc >= 0) ? sc / 2 : -((-sc + 1) / 2);
    e = sc - 2 * k;
    if (k >= 0) begin
      r = k + 2;
      pre = ((512'd1 << (k + 1)) - 512'd1) << 1;
    end else begin
      r = 1 - k;
      pre = 512'd1;
    end
    pre = (pre << 1) | 512'(e);
    xs = (pre << p) | (512'(mag) ^ (512'd1 << p));
    d = 15 - (r + 1) - p;
    rem = '0;
    half = '0;
    if (d >= 0) begin
      fld = xs << d;
    end else begin
      fld = xs >> (-d);
      rem = xs & ((512'd1 << (-d)) - 512'd1);
      half = 512'd1 << (-d - 1);
      if (rem > half || (rem == half && fld[0])) fld = fld + 512'd1;
    end
    inx = (rem != '0);
    sat = 1'b0;
    if (fld == '0) begin
      fld = 512'd1;
      sat = 1'b1;
    end else if (fld > 512'd32767) begin
      fld = 512'd32767;
      sat = 1'b1;
    end
    pos = fld[15:0];
    return {sat, inx | sat, q[127] ? 16'(-pos) : pos};
  endfunction

  function automatic logic [127:0] rand_q();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v = v >> $urandom_range(0, 127);
    if ($urandom_range(0, 1) == 1) v = -v;
    if ($urandom_range(0, 24) == 0) v = '0;
    if ($urandom_range(0, 24) == 0) v = NAR;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic hv;
    logic [17:0] hval;
    logic [17:0] e;
    hv = 1'b0;
    hval = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sent = sent - exp_q.size();
        exp_q.delete();
        hv = 1'b0;
      end else begin
        if (hv)
          check("stall_hold", 32'({m_valid, m_sat, m_inexact, m_posit}),
                32'({1'b1, hval}));
        if (m_valid && m_ready) begin
          got++;
          check("result_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("result", 32'({m_sat, m_inexact, m_posit}), 32'(e));
          end
        end
        hv = m_valid & ~m_ready;
        hval = {m_sat, m_inexact, m_posit};
        if (s_valid && s_ready) begin
          exp_q.push_back(use_spec ? spec_exp : ref_round(s_quire));
          sent++;
        end
      end
    end
  endtask

  task automatic send(input logic [127:0] q);
    int w;
    w = 0;
    s_quire = q;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("send_timeout", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic directed(input logic [127:0] q, input logic [17:0] e);
    use_spec = 1'b1;
    spec_exp = e;
    send(q);
    use_spec = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  int g0;

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_quire = '0;
    m_ready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_posit", 32'(m_posit), 32'd0);
    check("rst_m_inexact", 32'(m_inexact), 32'd0);
    check("rst_m_sat", 32'(m_sat), 32'd0);
    rst = 1'b0;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    m_ready = 1'b1;

    directed(128'd1 << 56, {2'b00, 16'h4000});
    directed(-(128'd1 << 56), {2'b00, 16'hC000});
    directed(128'd3 << 55, {2'b00, 16'h4800});
    directed((128'd1 << 56) + (128'd1 << 43), {2'b01, 16'h4000});
    directed((128'd1 << 56) + (128'd3 << 43), {2'b01, 16'h4002});
    directed(128'd1 << 120, {2'b11, 16'h7FFF});
    directed(128'd1, {2'b11, 16'h0001});
    directed({128{1'b1}}, {2'b11, 16'hFFFF});
    directed(128'd0, {2'b00, 16'h0000});
    directed(NAR, {2'b00, 16'h8000});
    drain("drain_directed");

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(rand_q());
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        for (int c = 0; c < 120; c++) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    m_ready = 1'b1;
    drain("drain_random");

    g0 = got;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_q());
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain("drain_stall");
    check("stall_count", 32'(got - g0), 32'd8);

    g0 = got;
    send(128'd1 << 56);
    send(128'd5 << 50);
    send(-(128'd7 << 60));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_flush_m_valid", 32'(m_valid), 32'd0);
    rst = 1'b0;
    check("rst_flush_s_ready", 32'(s_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_stale", 32'(got - g0), 32'd0);

    directed(128'd3 << 55, {2'b00, 16'h4800});
    drain("drain_after_rst");
    check("sent_eq_got", 32'(got), 32'(sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/posit_quire_round_pipe.md
POSIT_QUIRE_ROUND_PIPE -- requirements
Module: posit_quire_round_pipe

Interface
REQ-001 The block SHALL have parameter QUIRE_WIDTH, default 128, quire width in bits.
REQ-002 The block SHALL have parameter POSIT_WIDTH, default 16, output posit width n.
REQ-003 The block SHALL have parameter POSIT_ES, default 1, output posit exponent size es (0 legal).
REQ-004 The block SHALL have parameter QUIRE_FRAC, default 2^(POSIT_ES+1)*(POSIT_WIDTH-2), count of quire fraction bits (binary point position).
REQ-005 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port s_quire  input  QUIRE_WIDTH  two's-complement quire, value = s_quire * 2^-QUIRE_FRAC.
REQ-008 The block SHALL have port s_valid  input  1  s_quire valid.
REQ-009 The block SHALL have port s_ready  output  1  block accepts s_quire this cycle.
REQ-010 The block SHALL have port m_posit  output  POSIT_WIDTH  rounded posit result.
REQ-011 The block SHALL have port m_inexact  output  1  result differs from exact quire value.
REQ-012 The block SHALL have port m_sat  output  1  result clamped to maxpos or minpos.
REQ-013 The block SHALL have port m_valid  output  1  m_posit/m_inexact/m_sat valid.
REQ-014 The block SHALL have port m_ready  input  1  downstream accepts result.

Function
REQ-015 A transfer SHALL occur on s_valid&s_ready (input) and on m_valid&m_ready (output).
REQ-016 The pipeline SHALL have three register stages, enabled by en = ~m_valid | m_ready; s_ready SHALL equal en; latency 3 cycles with m_ready held high, throughput one result per cycle.
REQ-017 When en=0, all stage registers and stage-valid bits SHALL hold; outputs SHALL stay stable while m_valid&~m_ready.
REQ-018 Stage 1 SHALL register sign = MSB, magnitude = two's complement if negative, zero flag (all bits 0), NaR flag (MSB=1, rest 0).
REQ-019 Stage 2 SHALL leading-one detect the magnitude, compute signed scale = (QUIRE_WIDTH-1-lzc) - QUIRE_FRAC, and left-normalise the magnitude, keeping hidden bit, fraction, guard and a sticky OR of all lower bits.
REQ-020 Stage 3 SHALL build regime (k = scale>>>es), exponent (scale mod 2^es), fraction; shift right by regime length; round to nearest, ties to even, using guard and sticky over all bits shifted out.
REQ-021 A nonzero finite result SHALL never round to 0 or NaR: the unsigned magnitude field SHALL be clamped to [1, 2^(n-1)-1], setting m_sat when clamped.
REQ-022 A negative result SHALL be the two's complement of the full n-bit positive encoding.
REQ-023 Zero input SHALL give 0x0 with m_inexact=0, m_sat=0; NaR input SHALL give 1 followed by n-1 zeros, flags 0.
REQ-024 m_inexact SHALL be set iff guard|sticky is nonzero or the result was clamped.
REQ-025 Internal scale width SHALL be $clog2(QUIRE_WIDTH)+2 signed bits, so no scale overflow occurs for any legal input.

Reset
REQ-026 On rst=1 at a clock edge all stage-valid bits and m_valid SHALL clear to 0; m_posit, m_inexact and m_sat SHALL reset to 0.
REQ-027 Reset mid-operation SHALL discard all in-flight data; s_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-028 The stage-1/2/3 payload structs and the QUIRE_FRAC, maxpos and minpos helper macros or functions SHALL live in posit_defines.
REQ-029 The leading-one detector SHALL be the existing LOD_N sub-module; rounding/assembly SHALL be inline.

Verification (n=16, es=1, QUIRE_FRAC=56)
REQ-030 Bench case: s_quire=1<<56 -> m_posit=0x4000, flags 0; s_quire=-(1<<56) -> 0xC000.
REQ-031 Bench case: s_quire=3<<55 (1.5) -> 0x4800; s_quire=(1<<56)+(1<<43) (tie) -> 0x4000 with inexact=1; s_quire=(1<<56)+(3<<43) -> 0x4002 with inexact=1.
REQ-032 Bench case: s_quire=1<<120 -> 0x7FFF with m_sat=1; s_quire=1 -> 0x0001 with m_sat=1; s_quire=-1 -> 0xFFFF with m_sat=1.
REQ-033 Bench case: s_quire=0 -> 0x0000; s_quire=1<<127 -> 0x8000; flags 0 in both.
REQ-034 Bench case: 8 back-to-back inputs with m_ready low for 5 cycles mid-stream -> all 8 results emitted in order, none lost or duplicated, outputs stable while stalled.
REQ-035 Bench case: rst pulsed with 3 results in flight -> m_valid=0 the next cycle, no stale result later emitted.
